// File: rtl/decryption_pkg.sv
// Shared constants and types for the decryption register file and its access arbiter.
package decryption_pkg;

   localparam int unsigned ADDR_W      = 8;
   localparam int unsigned REG_W       = 16;
   localparam int unsigned TIMEOUT_DEF = 8;

   localparam logic [7:0] SELECT      = 8'h00;
   localparam logic [7:0] CAESAR_KEY  = 8'h10;
   localparam logic [7:0] SCYTALE_KEY = 8'h12;
   localparam logic [7:0] ZIGZAG_KEY  = 8'h14;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/decryption_regfile_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: on a tie the requester not served last wins.
module rr_arbiter2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic any_c,
   output logic winner_c
);

   always_comb begin
      any_c    = req0 | req1;
      winner_c = (req0 & req1) ? ~last_grant : req1;
   end

endmodule

// File: rtl/decryption_regfile_arbiter.sv
// Round-robin arbiter/sequencer sharing the decryption regfile port between two requesters.
// Optional WAIT timeout enabled by defining ARB_TIMEOUT_EN.
module decryption_regfile_arbiter
   import decryption_pkg::*;
#(
   parameter int unsigned addr_width     = ADDR_W,
   parameter int unsigned reg_width      = REG_W,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  req_write0,
   input  logic                  req_write1,
   input  logic [addr_width-1:0] req_addr0,
   input  logic [addr_width-1:0] req_addr1,
   input  logic [reg_width-1:0]  req_wdata0,
   input  logic [reg_width-1:0]  req_wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [reg_width-1:0]  rdata0,
   output logic [reg_width-1:0]  rdata1,
   output logic                  error0,
   output logic                  error1,
   output logic                  busy,
   output logic [addr_width-1:0] rf_addr,
   output logic                  rf_read,
   output logic                  rf_write,
   output logic [reg_width-1:0]  rf_wdata,
   input  logic [reg_width-1:0]  rf_rdata,
   input  logic                  rf_done,
   input  logic                  rf_error
);

   arb_state_e            state_q, state_d;
   logic                  gnt_q, gnt_d;
   logic                  last_grant_q, last_grant_d;
   logic                  is_write_q, is_write_d;
   logic [addr_width-1:0] rf_addr_q, rf_addr_d;
   logic [reg_width-1:0]  rf_wdata_q, rf_wdata_d;
   logic                  rf_read_q, rf_read_d;
   logic                  rf_write_q, rf_write_d;
   logic                  busy_q, busy_d;
   logic                  ack0_q, ack0_d;
   logic                  ack1_q, ack1_d;
   logic [reg_width-1:0]  rdata0_q, rdata0_d;
   logic [reg_width-1:0]  rdata1_q, rdata1_d;
   logic                  error0_q, error0_d;
   logic                  error1_q, error1_d;

   logic                  any_c;
   logic                  winner_c;
   logic                  sel_write_c;
   logic                  fin_c;
   logic                  fin_err_c;
   logic [reg_width-1:0]  fin_rdata_c;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   rr_arbiter2 u_rr (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant_q),
      .any_c      (any_c),
      .winner_c   (winner_c)
   );

   assign sel_write_c = winner_c ? req_write1 : req_write0;

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      is_write_d   = is_write_q;
      rf_addr_d    = rf_addr_q;
      rf_wdata_d   = rf_wdata_q;
      rf_read_d    = 1'b0;
      rf_write_d   = 1'b0;
      busy_d       = busy_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      error0_d     = error0_q;
      error1_d     = error1_q;
      fin_c        = 1'b0;
      fin_err_c    = 1'b0;
      fin_rdata_c  = '0;
`ifdef ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (any_c) begin
               gnt_d      = winner_c;
               is_write_d = sel_write_c;
               rf_addr_d  = winner_c ? req_addr1 : req_addr0;
               rf_wdata_d = winner_c ? req_wdata1 : req_wdata0;
               rf_write_d = sel_write_c;
               rf_read_d  = ~sel_write_c;
               busy_d     = 1'b1;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_WAIT: begin
            // Write completions report zero data regardless of what the regfile drives.
            if (rf_done) begin
               fin_c       = 1'b1;
               fin_err_c   = rf_error;
               fin_rdata_c = is_write_q ? '0 : rf_rdata;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               fin_c     = 1'b1;
               fin_err_c = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_ACK: begin
            last_grant_d = gnt_q;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Completion is routed only to the granted side; the other side keeps its last result.
      if (fin_c) begin
         state_d = ST_ACK;
         if (gnt_q) begin
            ack1_d   = 1'b1;
            rdata1_d = fin_rdata_c;
            error1_d = fin_err_c;
         end else begin
            ack0_d   = 1'b1;
            rdata0_d = fin_rdata_c;
            error0_d = fin_err_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         is_write_q   <= 1'b0;
         rf_addr_q    <= '0;
         rf_wdata_q   <= '0;
         rf_read_q    <= 1'b0;
         rf_write_q   <= 1'b0;
         busy_q       <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         error0_q     <= 1'b0;
         error1_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         is_write_q   <= is_write_d;
         rf_addr_q    <= rf_addr_d;
         rf_wdata_q   <= rf_wdata_d;
         rf_read_q    <= rf_read_d;
         rf_write_q   <= rf_write_d;
         busy_q       <= busy_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         error0_q     <= error0_d;
         error1_q     <= error1_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign error0   = error0_q;
   assign error1   = error1_q;
   assign busy     = busy_q;
   assign rf_addr  = rf_addr_q;
   assign rf_read  = rf_read_q;
   assign rf_write = rf_write_q;
   assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_decryption_regfile_arbiter.sv
// Scoreboard bench for decryption_regfile_arbiter with a behavioural regfile stub.
`timescale 1ns/1ps
module tb_decryption_regfile_arbiter;
   import decryption_pkg::*;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic        req_write0 = 1'b0, req_write1 = 1'b0;
   logic [7:0]  req_addr0 = '0, req_addr1 = '0;
   logic [15:0] req_wdata0 = '0, req_wdata1 = '0;
   logic        ack0, ack1, error0, error1, busy, rf_read, rf_write;
   logic [15:0] rdata0, rdata1, rf_wdata;
   logic [7:0]  rf_addr;
   logic [15:0] rf_rdata = '0;
   logic        rf_done = 1'b0, rf_error = 1'b0;

   decryption_regfile_arbiter #(.addr_width(8), .reg_width(16), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .req_write0(req_write0), .req_write1(req_write1),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .error0(error0), .error1(error1), .busy(busy),
      .rf_addr(rf_addr), .rf_read(rf_read), .rf_write(rf_write), .rf_wdata(rf_wdata),
      .rf_rdata(rf_rdata), .rf_done(rf_done), .rf_error(rf_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, expv);
      end
   endtask

   // Reference model: expected completions and register contents
   typedef struct {
      logic        who;
      logic [15:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] ref_mem [256];
   logic [15:0] rf_mem  [256];
   logic        last_gnt = 1'b1;

   function automatic logic addr_ok(input logic [7:0] a);
      return (a == SELECT) || (a == CAESAR_KEY) || (a == SCYTALE_KEY) || (a == ZIGZAG_KEY);
   endfunction

   function automatic exp_t model_op(input logic who, input logic wr, input logic [7:0] a,
                                     input logic [15:0] wd, input int c);
      exp_t e;
      e.who   = who;
      e.cyc   = c;
      e.err   = !addr_ok(a);
      e.rdata = '0;
      if (!e.err) begin
         if (wr) ref_mem[a] = wd;
         else    e.rdata = ref_mem[a];
      end
      return e;
   endfunction

   // Regfile stub: answers a strobe after dly extra WAIT cycles, injects stray done pulses when idle
   int          dly = 0;
   logic        stub_mute = 1'b0;
   logic        s_pend = 1'b0;
   int          s_cnt = 0;
   logic [7:0]  s_addr;
   logic        s_wr;
   logic [15:0] s_wd;

   always @(negedge clk) begin
      rf_done  = 1'b0;
      rf_error = 1'b0;
      rf_rdata = 16'($urandom);
      if (!rst_n) begin
         s_pend = 1'b0;
      end else if (rf_read || rf_write) begin
         chk("strobe_single", {30'd0, s_pend, rf_read & rf_write}, 32'd0);
         s_pend = 1'b1;
         s_cnt  = dly;
         s_addr = rf_addr;
         s_wr   = rf_write;
         s_wd   = rf_wdata;
      end else if (s_pend && !stub_mute) begin
         if (s_cnt == 0) begin
            chk("rf_hold", {8'd0, rf_addr, rf_wdata}, {8'd0, s_addr, s_wd});
            rf_done = 1'b1;
            if (addr_ok(s_addr)) begin
               if (s_wr) rf_mem[s_addr] = s_wd;
               else      rf_rdata = rf_mem[s_addr];
            end else begin
               rf_error = 1'b1;
               if (!s_wr) rf_rdata = '0;
            end
            s_pend = 1'b0;
         end else begin
            s_cnt--;
         end
      end else if (!s_pend && $urandom_range(0, 5) == 0) begin
         rf_done  = 1'b1;
         rf_error = 1'($urandom);
      end
   end

   // Monitor: pops expected completions on every ack, checks non-granted results hold
   logic [15:0] h_rd0 = '0, h_rd1 = '0;
   logic        h_e0 = 1'b0, h_e1 = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         h_rd0 = '0; h_rd1 = '0; h_e0 = 1'b0; h_e1 = 1'b0;
      end else begin
         if (ack0 || ack1) begin
            chk("dual_ack", {31'd0, ack0 & ack1}, 32'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("ack_who", {31'd0, ack1}, {31'd0, e.who});
               chk("ack_cycle", cyc, e.cyc);
               chk("ack_rdata", {16'd0, (ack1 ? rdata1 : rdata0)}, {16'd0, e.rdata});
               chk("ack_error", {31'd0, (ack1 ? error1 : error0)}, {31'd0, e.err});
               chk("ack_busy", {31'd0, busy}, 32'd1);
            end
         end
         if (ack0) begin h_rd0 = rdata0; h_e0 = error0; end
         else chk("hold0", {15'd0, error0, rdata0}, {15'd0, h_e0, h_rd0});
         if (ack1) begin h_rd1 = rdata1; h_e1 = error1; end
         else chk("hold1", {15'd0, error1, rdata1}, {15'd0, h_e1, h_rd1});
      end
   end

   logic        st_w [2];
   logic [7:0]  st_a [2];
   logic [15:0] st_d [2];

   task automatic chk_zero(input string tag);
      chk({tag, "_ack"},   {30'd0, ack1, ack0}, 32'd0);
      chk({tag, "_rdata"}, {rdata1, rdata0}, 32'd0);
      chk({tag, "_error"}, {30'd0, error1, error0}, 32'd0);
      chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
      chk({tag, "_rf"},    {6'd0, rf_read, rf_write, rf_addr, rf_wdata}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst_n    = 1'b1;
      last_gnt = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_acks(input int lim);
      int n = 0;
      while ((req0 || req1) && n < lim) begin
         @(negedge clk);
         n++;
         if (ack0) req0 = 1'b0;
         if (ack1) req1 = 1'b0;
      end
      chk("ack_arrived", {30'd0, req1, req0}, 32'd0);
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   // One arbitration round started in an IDLE cycle; checks busy and strobe timing per cycle
   task automatic round(input logic r0, input logic r1, input int d);
      int   c0, a1, a2, n;
      logic first, two;
      logic [1:0] exp_s;
      two   = r0 & r1;
      first = two ? ~last_gnt : r1;
      dly   = d;
      req_write0 = st_w[0]; req_addr0 = st_a[0]; req_wdata0 = st_d[0];
      req_write1 = st_w[1]; req_addr1 = st_a[1]; req_wdata1 = st_d[1];
      req0 = r0;
      req1 = r1;
      c0 = cyc;
      a1 = c0 + 3 + d;
      a2 = a1 + 4 + d;
      exp_q.push_back(model_op(first, st_w[first], st_a[first], st_d[first], a1));
      last_gnt = first;
      if (two) begin
         exp_q.push_back(model_op(~first, st_w[~first], st_a[~first], st_d[~first], a2));
         last_gnt = ~first;
      end
      n = 0;
      while ((req0 || req1) && n < 60) begin
         @(negedge clk);
         n++;
         chk("busy", {31'd0, busy},
             {31'd0, ((cyc >= c0 + 1) && (cyc <= a1)) || (two && (cyc >= a1 + 2) && (cyc <= a2))});
         exp_s = 2'b00;
         if (cyc == c0 + 1)              exp_s = st_w[first]  ? 2'b10 : 2'b01;
         else if (two && cyc == a1 + 2)  exp_s = st_w[~first] ? 2'b10 : 2'b01;
         chk("strobe_timing", {30'd0, rf_write, rf_read}, {30'd0, exp_s});
         if (ack0) req0 = 1'b0;
         if (ack1) req1 = 1'b0;
      end
      chk("round_done", {30'd0, req1, req0}, 32'd0);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic held6();
      int   c0, n, acks;
      logic who;
      dly = 0;
      req_write0 = 1'b0; req_addr0 = CAESAR_KEY;
      req_write1 = 1'b0; req_addr1 = ZIGZAG_KEY;
      req0 = 1'b1;
      req1 = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 6; i++) begin
         who = ~last_gnt;
         exp_q.push_back(model_op(who, 1'b0, who ? ZIGZAG_KEY : CAESAR_KEY, 16'd0, c0 + 3 + 4 * i));
         last_gnt = who;
      end
      acks = 0;
      n    = 0;
      while (acks < 6 && n < 80) begin
         @(negedge clk);
         n++;
         if (ack0 || ack1) acks++;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      chk("held6_acks", acks, 6);
      @(negedge clk);
   endtask

   function automatic logic [7:0] pick_addr();
      case ($urandom_range(0, 5))
         0: return SELECT;
         1: return CAESAR_KEY;
         2: return SCYTALE_KEY;
         3: return ZIGZAG_KEY;
         4: return 8'h05;
         default: return 8'hFF;
      endcase
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int   c0;
      logic r0, r1;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = '0;
         rf_mem[i]  = '0;
      end
      ref_mem[SCYTALE_KEY] = 16'hFFFF; rf_mem[SCYTALE_KEY] = 16'hFFFF;
      ref_mem[ZIGZAG_KEY]  = 16'h0002; rf_mem[ZIGZAG_KEY]  = 16'h0002;
      do_reset();

      // write then read back via requester 0
      st_w[0] = 1'b1; st_a[0] = CAESAR_KEY; st_d[0] = 16'h0003;
      st_w[1] = 1'b0; st_a[1] = SELECT;     st_d[1] = 16'h0000;
      round(1'b1, 1'b0, 0);
      st_w[0] = 1'b0;
      round(1'b1, 1'b0, 0);

      // simultaneous requests right after reset: requester 0 wins the tie
      do_reset();
      st_w[0] = 1'b0; st_a[0] = ZIGZAG_KEY;
      st_w[1] = 1'b1; st_a[1] = SCYTALE_KEY; st_d[1] = 16'h0005;
      round(1'b1, 1'b1, 0);

      // invalid address write, then confirm keys untouched
      st_w[1] = 1'b1; st_a[1] = 8'h05; st_d[1] = 16'hBEEF;
      round(1'b0, 1'b1, 0);
      st_w[1] = 1'b0; st_a[1] = SCYTALE_KEY;
      round(1'b0, 1'b1, 1);

      do_reset();
      held6();

      for (int k = 0; k < 40; k++) begin
         for (int j = 0; j < 2; j++) begin
            st_w[j] = 1'($urandom);
            st_a[j] = pick_addr();
            st_d[j] = 16'($urandom);
         end
         r0 = 1'($urandom);
         r1 = r0 ? 1'($urandom) : 1'b1;
         round(r0, r1, int'($urandom_range(0, 2)));
      end

      // reset during WAIT with the request still held
      dly = 6;
      req_write0 = 1'b0; req_addr0 = CAESAR_KEY;
      req0 = 1'b1;
      repeat (2) @(negedge clk);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero("midreset");
      @(negedge clk);
      rst_n    = 1'b1;
      last_gnt = 1'b1;
      dly      = 0;
      c0       = cyc;
      exp_q.push_back(model_op(1'b0, 1'b0, CAESAR_KEY, 16'd0, c0 + 3));
      last_gnt = 1'b0;
      wait_acks(30);
      @(negedge clk);

      // regfile never answers
      stub_mute = 1'b1;
      req_write0 = 1'b0; req_addr0 = CAESAR_KEY;
      req0 = 1'b1;
      c0 = cyc;
`ifdef ARB_TIMEOUT_EN
      exp_q.push_back('{who: 1'b0, rdata: 16'd0, err: 1'b1, cyc: c0 + 2 + int'(TO)});
      wait_acks(40);
`else
      repeat (100) @(negedge clk);
      chk("no_timeout_busy", {31'd0, busy}, 32'd1);
      chk("no_timeout_ack", {30'd0, ack1, ack0}, 32'd0);
      req0 = 1'b0;
`endif
      do_reset();
      stub_mute = 1'b0;

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
